// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the ID-stage front end and the pipelined control unit.
// The unit binds to the slave modport, and the driver of the ID stage binds to the master modport.
interface pipe_ctrl_if #(
    parameter int unsigned OPW    = 6,
    parameter int unsigned REGW   = 5,
    parameter int unsigned ALUOPW = 3,
    parameter int unsigned CNTW   = 8
) ();
    logic              id_valid;
    logic [OPW-1:0]    id_opcode;
    logic [REGW-1:0]   id_rs;
    logic [REGW-1:0]   id_rt;
    logic [REGW-1:0]   id_rd;
    logic              ex_branch_taken;
    logic              freeze;
    logic              stall;
    logic              flush_ifid;
    logic [ALUOPW-1:0] ex_aluop;
    logic              ex_alusrc;
    logic              ex_branch;
    logic              ex_bne;
    logic              ex_memread;
    logic [REGW-1:0]   ex_wreg;
    logic              mem_memread;
    logic              mem_memwrite;
    logic              mem_regwrite;
    logic              mem_memtoreg;
    logic [REGW-1:0]   mem_wreg;
    logic              wb_regwrite;
    logic              wb_memtoreg;
    logic [REGW-1:0]   wb_wreg;
    logic              illegal;
    logic [CNTW-1:0]   illegal_cnt;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken, freeze,
        input  stall, flush_ifid, ex_aluop, ex_alusrc, ex_branch, ex_bne, ex_memread, ex_wreg,
        input  mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_wreg,
        input  wb_regwrite, wb_memtoreg, wb_wreg, illegal, illegal_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken, freeze,
        output stall, flush_ifid, ex_aluop, ex_alusrc, ex_branch, ex_bne, ex_memread, ex_wreg,
        output mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_wreg,
        output wb_regwrite, wb_memtoreg, wb_wreg, illegal, illegal_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID opcode, carries controls through ID/EX, EX/MEM and
// MEM/WB, and handles load-use stalls, branch/jump flushes, freeze and illegal-opcode counting.
module pipe_ctrl_unit #(
    parameter int unsigned OPW    = 6,
    parameter int unsigned REGW   = 5,
    parameter int unsigned ALUOPW = 3,
    parameter int unsigned CNTW   = 8
) (
    input logic       clk,
    input logic       rst_n,
    pipe_ctrl_if.slave bus
);
    localparam logic [OPW-1:0] OpRtype = OPW'(0);
    localparam logic [OPW-1:0] OpJ     = OPW'(2);
    localparam logic [OPW-1:0] OpBeq   = OPW'(4);
    localparam logic [OPW-1:0] OpBne   = OPW'(5);
    localparam logic [OPW-1:0] OpAddi  = OPW'(8);
    localparam logic [OPW-1:0] OpSlti  = OPW'(10);
    localparam logic [OPW-1:0] OpAndi  = OPW'(12);
    localparam logic [OPW-1:0] OpOri   = OPW'(13);
    localparam logic [OPW-1:0] OpLw    = OPW'(35);
    localparam logic [OPW-1:0] OpSw    = OPW'(43);

    localparam logic [ALUOPW-1:0] AluAdd   = ALUOPW'(0);
    localparam logic [ALUOPW-1:0] AluSub   = ALUOPW'(1);
    localparam logic [ALUOPW-1:0] AluFunct = ALUOPW'(2);
    localparam logic [ALUOPW-1:0] AluAnd   = ALUOPW'(3);
    localparam logic [ALUOPW-1:0] AluOr    = ALUOPW'(4);
    localparam logic [ALUOPW-1:0] AluSlt   = ALUOPW'(5);

    typedef struct packed {
        logic [ALUOPW-1:0] aluop;
        logic              alusrc;
        logic              branch;
        logic              bne;
        logic              memread;
        logic              memwrite;
        logic              regwrite;
        logic              memtoreg;
        logic [REGW-1:0]   wreg;
    } idex_t;

    idex_t           dec, idex_d, idex_q;
    logic            rs_used, rt_used, is_jump, is_illegal, load_use;
    logic            mem_memread_q, mem_memwrite_q, mem_regwrite_q, mem_memtoreg_q;
    logic [REGW-1:0] mem_wreg_q, wb_wreg_q;
    logic            wb_regwrite_q, wb_memtoreg_q;
    logic            illegal_d, illegal_q;
    logic [CNTW-1:0] cnt_d, cnt_q;

    always_comb begin
        dec        = '0;
        rs_used    = 1'b0;
        rt_used    = 1'b0;
        is_jump    = 1'b0;
        is_illegal = 1'b0;
        if (bus.id_valid) begin
            rs_used = 1'b1;
            case (bus.id_opcode)
                OpRtype: begin
                    dec.aluop = AluFunct; dec.regwrite = 1'b1; dec.wreg = bus.id_rd;
                    rt_used   = 1'b1;
                end
                OpLw: begin
                    dec.aluop    = AluAdd; dec.alusrc = 1'b1; dec.memread = 1'b1;
                    dec.memtoreg = 1'b1;   dec.regwrite = 1'b1; dec.wreg = bus.id_rt;
                end
                OpSw: begin
                    dec.aluop = AluAdd; dec.alusrc = 1'b1; dec.memwrite = 1'b1;
                    rt_used   = 1'b1;
                end
                OpBeq: begin
                    dec.aluop = AluSub; dec.branch = 1'b1; rt_used = 1'b1;
                end
                OpBne: begin
                    dec.aluop = AluSub; dec.branch = 1'b1; dec.bne = 1'b1; rt_used = 1'b1;
                end
                OpJ: begin
                    is_jump = 1'b1; rs_used = 1'b0;
                end
                OpAddi, OpAndi, OpOri, OpSlti: begin
                    dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.wreg = bus.id_rt;
                    unique case (bus.id_opcode)
                        OpAndi:  dec.aluop = AluAnd;
                        OpOri:   dec.aluop = AluOr;
                        OpSlti:  dec.aluop = AluSlt;
                        default: dec.aluop = AluAdd;
                    endcase
                end
                default: begin
                    is_illegal = 1'b1; rs_used = 1'b0;
                end
            endcase
            // Writes to register 0 are architecturally discarded.
            if (dec.wreg == '0) dec.regwrite = 1'b0;
        end
    end

    always_comb begin
        load_use = idex_q.memread && (idex_q.wreg != '0) && bus.id_valid &&
                   ((rs_used && (idex_q.wreg == bus.id_rs)) ||
                    (rt_used && (idex_q.wreg == bus.id_rt)));
        bus.stall      = load_use && !bus.ex_branch_taken && !bus.freeze;
        bus.flush_ifid = !bus.freeze && (bus.ex_branch_taken || is_jump);
        idex_d = (bus.ex_branch_taken || load_use) ? '0 : dec;
        illegal_d = !bus.freeze && is_illegal;
        cnt_d = cnt_q;
        if (illegal_d && (cnt_q != '1)) cnt_d = cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q         <= '0;
            mem_memread_q  <= 1'b0;
            mem_memwrite_q <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_wreg_q     <= '0;
            wb_regwrite_q  <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_wreg_q      <= '0;
            illegal_q      <= 1'b0;
            cnt_q          <= '0;
        end else begin
            illegal_q <= illegal_d;
            if (!bus.freeze) begin
                idex_q         <= idex_d;
                mem_memread_q  <= idex_q.memread;
                mem_memwrite_q <= idex_q.memwrite;
                mem_regwrite_q <= idex_q.regwrite;
                mem_memtoreg_q <= idex_q.memtoreg;
                mem_wreg_q     <= idex_q.wreg;
                wb_regwrite_q  <= mem_regwrite_q;
                wb_memtoreg_q  <= mem_memtoreg_q;
                wb_wreg_q      <= mem_wreg_q;
                cnt_q          <= cnt_d;
            end
        end
    end

    assign bus.ex_aluop     = idex_q.aluop;
    assign bus.ex_alusrc    = idex_q.alusrc;
    assign bus.ex_branch    = idex_q.branch;
    assign bus.ex_bne       = idex_q.bne;
    assign bus.ex_memread   = idex_q.memread;
    assign bus.ex_wreg      = idex_q.wreg;
    assign bus.mem_memread  = mem_memread_q;
    assign bus.mem_memwrite = mem_memwrite_q;
    assign bus.mem_regwrite = mem_regwrite_q;
    assign bus.mem_memtoreg = mem_memtoreg_q;
    assign bus.mem_wreg     = mem_wreg_q;
    assign bus.wb_regwrite  = wb_regwrite_q;
    assign bus.wb_memtoreg  = wb_memtoreg_q;
    assign bus.wb_wreg      = wb_wreg_q;
    assign bus.illegal      = illegal_q;
    assign bus.illegal_cnt  = cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit; a second instance with a 2-bit counter shares the stimulus
// to exercise counter saturation.
module tb_pipe_ctrl_unit;
    localparam logic [5:0] R = 6'd0, J = 6'd2, BNE = 6'd5, ADDI = 6'd8, SLTI = 6'd10;
    localparam logic [5:0] ANDI = 6'd12, ORI = 6'd13, LW = 6'd35, SW = 6'd43, ILL = 6'd63;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    pipe_ctrl_if #(.CNTW(8)) bus ();
    pipe_ctrl_if #(.CNTW(2)) bus2 ();

    pipe_ctrl_unit #(.CNTW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    pipe_ctrl_unit #(.CNTW(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus2.id_valid        = bus.id_valid;
    assign bus2.id_opcode       = bus.id_opcode;
    assign bus2.id_rs           = bus.id_rs;
    assign bus2.id_rt           = bus.id_rt;
    assign bus2.id_rd           = bus.id_rd;
    assign bus2.ex_branch_taken = bus.ex_branch_taken;
    assign bus2.freeze          = bus.freeze;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_rd     = rd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ex_branch_taken = 1'b0;
        bus.freeze          = 1'b0;
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        #11;
        chk("rst_ex_memread", bus.ex_memread, 0);
        chk("rst_mem_regwrite", bus.mem_regwrite, 0);
        chk("rst_wb_regwrite", bus.wb_regwrite, 0);
        chk("rst_illegal_cnt", bus.illegal_cnt, 0);
        rst_n = 1'b1;

        // ADDI rt=5 walks through EX, MEM, WB
        drive(1'b1, ADDI, 5'd1, 5'd5, 5'd0);
        chk("addi_stall", bus.stall, 0);
        chk("addi_flush", bus.flush_ifid, 0);
        step();
        chk("addi_ex_aluop", bus.ex_aluop, 0);
        chk("addi_ex_alusrc", bus.ex_alusrc, 1);
        chk("addi_ex_wreg", bus.ex_wreg, 5);
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        step();
        chk("addi_mem_regwrite", bus.mem_regwrite, 1);
        chk("addi_mem_wreg", bus.mem_wreg, 5);
        chk("bubble_ex_alusrc", bus.ex_alusrc, 0);
        step();
        chk("addi_wb_regwrite", bus.wb_regwrite, 1);
        chk("addi_wb_wreg", bus.wb_wreg, 5);
        chk("bubble_mem_regwrite", bus.mem_regwrite, 0);

        // Extended I-type ALU codes and R-type
        drive(1'b1, ORI, 5'd1, 5'd7, 5'd0);  step(); chk("ori_aluop", bus.ex_aluop, 4);
        drive(1'b1, SLTI, 5'd1, 5'd8, 5'd0); step(); chk("slti_aluop", bus.ex_aluop, 5);
        drive(1'b1, ANDI, 5'd1, 5'd9, 5'd0); step(); chk("andi_aluop", bus.ex_aluop, 3);
        drive(1'b1, R, 5'd1, 5'd2, 5'd9);
        step();
        chk("r_aluop", bus.ex_aluop, 2);
        chk("r_wreg", bus.ex_wreg, 9);
        chk("r_alusrc", bus.ex_alusrc, 0);
        drive(1'b1, ADDI, 5'd1, 5'd0, 5'd0);
        step();
        chk("addi0_ex_wreg", bus.ex_wreg, 0);
        chk("r_mem_regwrite", bus.mem_regwrite, 1);
        chk("r_mem_wreg", bus.mem_wreg, 9);
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        step();
        chk("addi0_mem_regwrite", bus.mem_regwrite, 0);
        chk("r_wb_wreg", bus.wb_wreg, 9);

        // Branch / store controls
        drive(1'b1, BNE, 5'd1, 5'd2, 5'd0);
        step();
        chk("bne_aluop", bus.ex_aluop, 1);
        chk("bne_branch", bus.ex_branch, 1);
        chk("bne_bne", bus.ex_bne, 1);
        drive(1'b1, SW, 5'd1, 5'd2, 5'd0);
        step();
        chk("sw_alusrc", bus.ex_alusrc, 1);
        chk("sw_memread", bus.ex_memread, 0);
        chk("sw_branch", bus.ex_branch, 0);
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        step();
        chk("sw_mem_memwrite", bus.mem_memwrite, 1);
        chk("sw_mem_regwrite", bus.mem_regwrite, 0);

        // Load-use: LW r3 then ADD rs=r3
        drive(1'b1, LW, 5'd1, 5'd3, 5'd0);
        chk("lw_no_stall", bus.stall, 0);
        step();
        chk("lw_ex_memread", bus.ex_memread, 1);
        chk("lw_ex_wreg", bus.ex_wreg, 3);
        drive(1'b1, R, 5'd3, 5'd4, 5'd10);
        chk("lu_stall", bus.stall, 1);
        chk("lu_flush", bus.flush_ifid, 0);
        step();
        chk("lu_bubble_memread", bus.ex_memread, 0);
        chk("lu_bubble_wreg", bus.ex_wreg, 0);
        chk("lu_mem_memread", bus.mem_memread, 1);
        chk("lu_stall_released", bus.stall, 0);
        step();
        chk("lu_add_late_wreg", bus.ex_wreg, 10);
        chk("lu_add_late_aluop", bus.ex_aluop, 2);

        // No stall when the load targets r0 or the consumer does not read the register
        drive(1'b1, LW, 5'd1, 5'd0, 5'd0);
        step();
        drive(1'b1, R, 5'd0, 5'd0, 5'd10);
        chk("lu_dest0_no_stall", bus.stall, 0);
        drive(1'b1, LW, 5'd1, 5'd3, 5'd0);
        step();
        drive(1'b1, SW, 5'd4, 5'd5, 5'd0);
        chk("lu_sw_rs_differs", bus.stall, 0);
        drive(1'b1, SW, 5'd4, 5'd3, 5'd0);
        chk("lu_sw_rt_match", bus.stall, 1);
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        step();

        // Branch taken overrides a pending load-use stall
        drive(1'b1, LW, 5'd1, 5'd3, 5'd0);
        step();
        bus.ex_branch_taken = 1'b1;
        drive(1'b1, LW, 5'd3, 5'd6, 5'd0);
        chk("br_stall", bus.stall, 0);
        chk("br_flush", bus.flush_ifid, 1);
        step();
        chk("br_bubble_memread", bus.ex_memread, 0);
        bus.ex_branch_taken = 1'b0;

        // Jump flushes IF/ID unless frozen
        drive(1'b1, J, 5'd0, 5'd0, 5'd0);
        chk("j_flush", bus.flush_ifid, 1);
        chk("j_stall", bus.stall, 0);
        bus.freeze = 1'b1;
        #1;
        chk("j_frozen_flush", bus.flush_ifid, 0);
        bus.freeze = 1'b0;
        step();

        // Illegal opcode on five consecutive cycles
        drive(1'b1, ILL, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ill_pulse", bus.illegal, 1);
        end
        chk("ill_aluop", bus.ex_aluop, 0);
        chk("ill_alusrc", bus.ex_alusrc, 0);
        chk("ill_wreg", bus.ex_wreg, 0);
        chk("ill_cnt3", bus.illegal_cnt, 3);
        chk("ill_cnt2_at3", bus2.illegal_cnt, 3);
        step();
        step();
        chk("ill_cnt5", bus.illegal_cnt, 5);
        chk("ill_cnt2_sat", bus2.illegal_cnt, 3);
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        step();
        chk("ill_pulse_end", bus.illegal, 0);
        chk("ill_cnt_hold", bus.illegal_cnt, 5);

        // Freeze during a load-use stall
        drive(1'b1, LW, 5'd1, 5'd3, 5'd0);
        step();
        drive(1'b1, R, 5'd3, 5'd4, 5'd10);
        chk("frz_pre_stall", bus.stall, 1);
        bus.freeze = 1'b1;
        #1;
        chk("frz_stall", bus.stall, 0);
        step();
        step();
        chk("frz_ex_memread", bus.ex_memread, 1);
        chk("frz_ex_wreg", bus.ex_wreg, 3);
        chk("frz_mem_memread", bus.mem_memread, 0);
        chk("frz_stall_hold", bus.stall, 0);
        bus.freeze = 1'b0;
        #1;
        chk("frz_release_stall", bus.stall, 1);
        step();
        chk("frz_bubble", bus.ex_memread, 0);
        chk("frz_mem_lw", bus.mem_memread, 1);
        step();
        chk("frz_add_ex", bus.ex_wreg, 10);

        // Asynchronous reset with a load in EX
        drive(1'b1, LW, 5'd1, 5'd3, 5'd0);
        step();
        chk("prerst_ex_memread", bus.ex_memread, 1);
        chk("prerst_mem_regwrite", bus.mem_regwrite, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ex_memread", bus.ex_memread, 0);
        chk("arst_ex_wreg", bus.ex_wreg, 0);
        chk("arst_mem_regwrite", bus.mem_regwrite, 0);
        chk("arst_illegal_cnt", bus.illegal_cnt, 0);
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst_wb_regwrite", bus.wb_regwrite, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle opcode decoder.
- Decodes the ID-stage opcode into a control bundle with a parametrised ALU-op width and an extended I-type set.
- Carries the bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards (stall + bubble), handles jump/branch flushes, honours a global freeze, and counts illegal opcodes.

Parameters:
- OPW, 6, opcode width
- REGW, 5, register-address width
- ALUOPW, 3, ALU-op code width (must be ≥3)
- CNTW, 8, illegal-opcode counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  OPW  ID instruction opcode
- id_rs, id_rt, id_rd  in  REGW  ID register fields
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- freeze  in  1  global hold (memory wait)
- stall  out  1  hold PC and IF/ID (combinational)
- flush_ifid  out  1  squash IF/ID (combinational)
- ex_aluop  out  ALUOPW  EX ALU op
- ex_alusrc, ex_branch, ex_bne, ex_memread  out  1 each  EX-stage controls
- ex_wreg  out  REGW  EX destination register
- mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg  out  1 each  MEM-stage controls
- mem_wreg  out  REGW  MEM destination register
- wb_regwrite, wb_memtoreg  out  1 each  WB-stage controls
- wb_wreg  out  REGW  WB destination register
- illegal  out  1  registered one-cycle pulse on an undefined opcode
- illegal_cnt  out  CNTW  saturating count of illegal opcodes

Behaviour:

Reset:
- rst_n low clears every pipeline register, illegal and illegal_cnt to 0 immediately, regardless of clk.
- Pipeline then holds bubbles (all controls 0, wreg 0).

Decode (combinational; ALU codes: 000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt):
- R-type (0): aluop 010, RegDst=rd, regwrite.
- LW (35): aluop 000, alusrc, memread, memtoreg, regwrite, dest rt.
- SW (43): aluop 000, alusrc, memwrite.
- BEQ (4): aluop 001, branch.
- BNE (5): aluop 001, branch, bne.
- J (2): no datapath controls; flush_ifid=1 while in ID with id_valid and not freeze.
- ADDI (8): aluop 000, alusrc, regwrite, dest rt.
- ANDI (12): as ADDI with aluop 011.
- ORI (13): as ADDI with aluop 100.
- SLTI (10): as ADDI with aluop 101.
- Any other opcode with id_valid: all-zero bundle (never X); illegal=1 on the next edge; illegal_cnt increments and saturates at all-ones.
- regwrite is forced 0 whenever the destination is register 0; wreg is still carried.
- id_valid=0: decoded bundle is a bubble.

Sources used:
- rs is used by every opcode except J.
- rt is used by R-type, SW, BEQ and BNE only.

Hazard / flush (combinational):
- Load-use condition: ex_memread && ex_wreg != 0 && id_valid && (rs used && ex_wreg==id_rs || rt used && ex_wreg==id_rt).
- Load-use: stall=1; ID/EX loads a bubble at the next edge.
- ex_branch_taken: flush_ifid=1, ID/EX loads a bubble, stall=0. Branch takes priority over load-use.
- A jump in ID with ex_branch_taken also high is squashed. flush_ifid=1 either way.
- freeze=1: all pipeline registers and counters hold; stall=0; flush_ifid=0; illegal not pulsed.

Pipeline registers (advance every edge unless freeze):
- ID/EX: decoded bundle or bubble.
- EX/MEM: copy of ID/EX memory/WB fields.
- MEM/WB: copy of EX/MEM WB fields.
- Latency: decode to ex_* 1 cycle, mem_* 2 cycles, wb_* 3 cycles.

Test Plan:
- Reset: pulse rst_n low mid-run with a LW in EX -> all outputs 0 immediately; after release, 3 NOP cycles keep wb_regwrite=0.
- ADDI rt=5 at cycle 0 -> ex_aluop=000, ex_alusrc=1 at cycle 1; mem_regwrite=1 with mem_wreg=5 at cycle 2; wb_regwrite=1 with wb_wreg=5 at cycle 3.
- Load-use: LW rt=3 then ADD rs=3 -> stall=1 for exactly one cycle, one bubble in EX, ADD reaches EX one cycle late. Same case with dest 0 or a SW whose rs differs -> no stall.
- Branch: ex_branch_taken=1 while ID holds a LW that would cause a load-use stall -> stall=0, flush_ifid=1, next ex_memread=0.
- Illegal: opcode 63 with id_valid on 3 consecutive cycles -> illegal high 3 cycles, illegal_cnt=3, all controls 0. With CNTW=2 and 5 illegal opcodes -> illegal_cnt saturates at 3.
- Freeze: assert freeze 2 cycles during a load-use stall -> all stage outputs hold, stall=0 while frozen; stall reasserts for one cycle on release.
